// File: rtl/cpu_pkg.sv
// cpu_pkg: decoder phase codes, sequencer FSM states and phase-code mapping
package cpu_pkg;
  localparam logic [1:0] ST_FETCH = 2'b00;
  localparam logic [1:0] ST_EXEC1 = 2'b01;
  localparam logic [1:0] ST_EXEC2 = 2'b10;
  localparam logic [1:0] ST_IDLE  = 2'b11;

  typedef enum logic [2:0] {
    S_FETCH,
    S_EXEC1,
    S_EXEC2,
    S_IRQ_PUSH,
    S_IRQ_VEC,
    S_HALT
  } seq_state_e;

  function automatic logic [1:0] state_code(input seq_state_e s);
    return (s == S_FETCH) ? ST_FETCH :
           (s == S_EXEC1) ? ST_EXEC1 :
           (s == S_EXEC2) ? ST_EXEC2 : ST_IDLE;
  endfunction
endpackage

// File: rtl/cpu_sequencer_irq_latch.sv
// irq_latch: irq rising-edge detect into a pending flag; a new edge beats a same-cycle clear
module irq_latch (
  input  logic clk,
  input  logic rst,
  input  logic irq_i,
  input  logic clr_i,
  output logic pending_o
);
  logic irq_q, pending_q;
  // previous irq level and the sticky pending flag
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q     <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      irq_q     <= irq_i;
      pending_q <= (irq_i & ~irq_q) | (pending_q & ~clr_i);
    end
  end
  assign pending_o = pending_q;
endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: CPU control-path master FSM with IRQ entry; SEQ_WATCHDOG_EN adds a fetch-wait watchdog
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int                 ADDR_W     = 8,
  parameter logic [ADDR_W-1:0]  IRQ_VECTOR = 8'h02,
  parameter int                 CNT_W      = 16,
  parameter int                 WDT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              mem_ready,
  input  logic              sm_extra,
  input  logic              set_jump,
  input  logic              stop,
  input  logic              irq,
  input  logic              irq_en,
  output logic [1:0]        state,
  output logic              jump,
  output logic              halted,
  output logic              irq_push,
  output logic              irq_vec_load,
  output logic              irq_ack,
  output logic [ADDR_W-1:0] irq_vector,
  output logic [CNT_W-1:0]  retired,
  output logic              fault
);
  seq_state_e       fsm_q, fsm_d;
  logic             jump_q, jump_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             pending, boundary, take, in_exec, wdt_trip;

  irq_latch u_irq (
    .clk       (clk),
    .rst       (rst),
    .irq_i     (irq),
    .clr_i     (fsm_q == S_IRQ_VEC),
    .pending_o (pending)
  );

`ifdef SEQ_WATCHDOG_EN
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);
  logic [WDT_W-1:0] wdt_cnt_q;
  logic             fault_q;
  logic             fetch_wait;
  assign fetch_wait = (fsm_q == S_FETCH) && !mem_ready;
  assign wdt_trip   = fetch_wait && (wdt_cnt_q == WDT_W'(WDT_CYCLES - 1));
  // consecutive fetch-wait counter and sticky fault flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wdt_cnt_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      wdt_cnt_q <= (fetch_wait && !wdt_trip) ? wdt_cnt_q + 1'b1 : '0;
      fault_q   <= fault_q | wdt_trip;
    end
  end
  assign fault = fault_q;
`else
  logic unused_wdt;
  assign unused_wdt = ^WDT_CYCLES;
  assign wdt_trip   = 1'b0;
  assign fault      = 1'b0;
`endif

  // next state, jump flag and retired count
  always_comb begin
    in_exec   = (fsm_q == S_EXEC1) || (fsm_q == S_EXEC2);
    boundary  = !stop && (((fsm_q == S_EXEC1) && !sm_extra) || (fsm_q == S_EXEC2));
    take      = boundary && pending && irq_en;
    fsm_d     = fsm_q;
    case (fsm_q)
      S_FETCH:    fsm_d = mem_ready ? S_EXEC1 : wdt_trip ? S_HALT : S_FETCH;
      S_EXEC1:    fsm_d = stop ? S_HALT : sm_extra ? S_EXEC2 : take ? S_IRQ_PUSH : S_FETCH;
      S_EXEC2:    fsm_d = stop ? S_HALT : take ? S_IRQ_PUSH : S_FETCH;
      S_IRQ_PUSH: fsm_d = S_IRQ_VEC;
      S_IRQ_VEC:  fsm_d = S_FETCH;
      S_HALT:     fsm_d = (run && !fault) ? S_FETCH : S_HALT;
      default:    fsm_d = S_FETCH;
    endcase
    jump_d    = (fsm_q == S_EXEC1)   ? set_jump :
                (fsm_q == S_EXEC2)   ? (jump_q | set_jump) :
                (fsm_q == S_IRQ_VEC) ? 1'b1 : jump_q;
    retired_d = retired_q + CNT_W'(boundary || (in_exec && stop));
  end

  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q     <= S_FETCH;
      jump_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      fsm_q     <= fsm_d;
      jump_q    <= jump_d;
      retired_q <= retired_d;
    end
  end

  assign state        = state_code(fsm_q);
  assign halted       = (fsm_q == S_HALT);
  assign irq_push     = (fsm_q == S_IRQ_PUSH);
  assign irq_vec_load = (fsm_q == S_IRQ_VEC);
  assign irq_ack      = (fsm_q == S_IRQ_VEC);
  assign irq_vector   = IRQ_VECTOR;
  assign jump         = jump_q;
  assign retired      = retired_q;
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed test-plan steps plus random stimulus against a phase-level reference model
module tb_cpu_sequencer;
`ifdef SEQ_WATCHDOG_EN
  localparam int WDT = 4;
`else
  localparam int WDT = 0;
`endif
  logic clk = 1'b0, rst = 1'b1, run = 1'b0, mem_ready = 1'b0, sm_extra = 1'b0;
  logic set_jump = 1'b0, stop = 1'b0, irq = 1'b0, irq_en = 1'b0;
  logic [1:0] state;
  logic jump, halted, irq_push, irq_vec_load, irq_ack, fault;
  logic [7:0] irq_vector;
  logic [15:0] retired;
  int checks = 0, failures = 0;

  string m_ph;
  logic m_jump, m_pend, m_irqp, m_fault;
  logic [15:0] m_ret;
  int m_wait;

`ifdef SEQ_WATCHDOG_EN
  cpu_sequencer #(.WDT_CYCLES(4)) dut (
`else
  cpu_sequencer dut (
`endif
    .clk(clk), .rst(rst), .run(run), .mem_ready(mem_ready), .sm_extra(sm_extra),
    .set_jump(set_jump), .stop(stop), .irq(irq), .irq_en(irq_en), .state(state),
    .jump(jump), .halted(halted), .irq_push(irq_push), .irq_vec_load(irq_vec_load),
    .irq_ack(irq_ack), .irq_vector(irq_vector), .retired(retired), .fault(fault));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] m_code();
    if (m_ph == "FETCH") return 2'd0;
    if (m_ph == "EXEC1") return 2'd1;
    if (m_ph == "EXEC2") return 2'd2;
    return 2'd3;
  endfunction

  task automatic model_edge();
    logic rise;
    if (rst) begin
      m_ph = "FETCH"; m_jump = 0; m_pend = 0; m_irqp = 0; m_fault = 0; m_ret = 0; m_wait = 0;
      return;
    end
    rise = irq && !m_irqp;
    m_irqp = irq;
    if (m_ph == "FETCH") begin
      if (mem_ready) begin
        m_ph = "EXEC1"; m_wait = 0;
      end else begin
        m_wait++;
        if (WDT > 0 && m_wait >= WDT) begin
          m_ph = "HALT"; m_fault = 1; m_wait = 0;
        end
      end
    end else if (m_ph == "EXEC1" || m_ph == "EXEC2") begin
      if (m_ph == "EXEC1") m_jump = set_jump;
      else m_jump = m_jump | set_jump;
      if (stop) begin
        m_ret++; m_ph = "HALT";
      end else if (m_ph == "EXEC1" && sm_extra) begin
        m_ph = "EXEC2";
      end else begin
        m_ret++;
        if (m_pend && irq_en) m_ph = "IRQ_PUSH";
        else m_ph = "FETCH";
      end
    end else if (m_ph == "IRQ_PUSH") begin
      m_ph = "IRQ_VEC";
    end else if (m_ph == "IRQ_VEC") begin
      m_pend = 0; m_jump = 1; m_ph = "FETCH";
    end else if (run && !m_fault) begin
      m_ph = "FETCH";
    end
    if (rise) m_pend = 1;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("state", state, m_code());
    chk("jump", jump, m_jump);
    chk("halted", halted, m_ph == "HALT");
    chk("irq_push", irq_push, m_ph == "IRQ_PUSH");
    chk("irq_vec_load", irq_vec_load, m_ph == "IRQ_VEC");
    chk("irq_ack", irq_ack, m_ph == "IRQ_VEC");
    chk("irq_vector", irq_vector, 8'h02);
    chk("retired", retired, m_ret);
    chk("fault", fault, m_fault);
  endtask

  task automatic do_reset();
    rst = 1; cyc(); cyc(); rst = 0;
  endtask

  initial begin
    do_reset();
    chk("rst_state", state, 2'b00);
    chk("rst_retired", retired, 16'd0);
    mem_ready = 1; irq_en = 1;
    cyc(); chk("seq1", state, 2'b01);
    cyc(); chk("seq2", state, 2'b00);
    cyc(); chk("seq3", state, 2'b01);
    cyc(); chk("seq_ret", retired, 16'd2);
    cyc(); sm_extra = 1;
    cyc(); sm_extra = 0; chk("ex2_state", state, 2'b10); chk("ex2_ret", retired, 16'd2);
    cyc(); chk("ex2_exit", state, 2'b00); chk("ex2_ret_inc", retired, 16'd3);
    cyc(); set_jump = 1;
    cyc(); set_jump = 0; chk("jmp_fetch", jump, 1'b1);
    cyc(); chk("jmp_exec1", jump, 1'b1);
    cyc(); chk("jmp_clear", jump, 1'b0);
    cyc(); irq = 1; sm_extra = 1;
    cyc(); irq = 0; sm_extra = 0; chk("irq_ex2", state, 2'b10);
    cyc(); chk("irq_push_st", state, 2'b11); chk("irq_push_pulse", irq_push, 1'b1);
    cyc(); chk("irq_vec", irq_vec_load & irq_ack, 1'b1); chk("irq_vector_v", irq_vector, 8'h02);
    cyc(); chk("irq_fetch", state, 2'b00); chk("irq_jump", jump, 1'b1);
    irq_en = 0;
    cyc(); irq = 1; sm_extra = 1;
    cyc(); irq = 0; sm_extra = 0;
    cyc(); chk("noen_fetch", state, 2'b00); chk("noen_push", irq_push, 1'b0);
    cyc(); irq_en = 1;
    cyc(); chk("late_push", irq_push, 1'b1);
    cyc(); cyc();
    irq = 1;
    cyc(); irq = 0; stop = 1;
    cyc(); stop = 0; chk("stp_halt", halted, 1'b1); chk("stp_state", state, 2'b11);
    chk("stp_nopush", irq_push, 1'b0);
    cyc(); chk("halt_hold", halted, 1'b1); run = 1;
    cyc(); run = 0; chk("run_fetch", state, 2'b00); chk("run_halted", halted, 1'b0);
    cyc();
    cyc(); chk("halt_irq_push", irq_push, 1'b1);
    rst = 1;
    cyc(); rst = 0; chk("rst_push", irq_push, 1'b0); chk("rst_st", state, 2'b00);
    chk("rst_ret2", retired, 16'd0); chk("rst_jump", jump, 1'b0);
    mem_ready = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(); run = 1;
    end
    run = 0;
`ifdef SEQ_WATCHDOG_EN
    chk("wdt_fault", fault, 1'b1); chk("wdt_halt", halted, 1'b1);
`else
    chk("wdt_fault", fault, 1'b0); chk("wdt_fetch", state, 2'b00);
`endif
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      mem_ready = ($urandom_range(0, 3) != 0);
      sm_extra  = 1'($urandom);
      set_jump  = 1'($urandom);
      stop      = ($urandom_range(0, 15) == 0);
      run       = ($urandom_range(0, 3) == 0);
      irq_en    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) irq = ~irq;
      cyc();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
